// File: rtl/bin_shift_scheduler.sv
// bin_shift_scheduler
// Walks the source bins of one spectral frame. For each bin it emits a
// (src, dst) pair, where dst is k * shift_factor rounded to the nearest bin.
// An accumulator replaces the per-bin multiply. The frame ends on the last
// source bin, or at the first destination that falls outside the spectrum.
//
// Build option: define BIN_SHIFT_ROUND_EVEN_EN to round exact .5 ties to the
// even bin. Without it, ties round half up.
module bin_shift_scheduler #(
  parameter int INT_WIDTH  = 11,
  parameter int FRAC_WIDTH = 21,
  parameter int N_BINS     = 1024,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [INT_WIDTH+FRAC_WIDTH-1:0] shift_factor,
  output logic                            busy,
  output logic                            done,
  output logic                            map_valid,
  input  logic                            map_ready,
  output logic [ADDR_WIDTH-1:0]           src_addr,
  output logic [ADDR_WIDTH-1:0]           dst_addr,
  output logic [ADDR_WIDTH:0]             map_count
);

  localparam int FW    = INT_WIDTH + FRAC_WIDTH;
  localparam int ACC_W = ADDR_WIDTH + FW;
  localparam int IP_W  = ADDR_WIDTH + INT_WIDTH;
  localparam int RND_W = IP_W + 1;  // headroom so the +1 round-up cannot wrap
  localparam logic [RND_W-1:0]      N_BINS_R = RND_W'(N_BINS);
  localparam logic [ADDR_WIDTH-1:0] LAST_SRC = ADDR_WIDTH'(N_BINS - 1);

`ifdef BIN_SHIFT_ROUND_EVEN_EN
  localparam logic HALF_UP = 1'b0;
`else
  localparam logic HALF_UP = 1'b1;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  // Round to nearest. When HALF_UP is clear, an exact tie rounds only if the
  // integer part is odd, which lands the result on the even bin.
  function automatic logic [RND_W-1:0] round_acc(input logic [ACC_W-1:0] a);
    logic [IP_W-1:0] ip;
    logic            half;
    logic            rest_nz;
    logic            up;
    ip      = a[ACC_W-1:FRAC_WIDTH];
    half    = a[FRAC_WIDTH-1];
    rest_nz = |a[FRAC_WIDTH-2:0];
    up      = half & (rest_nz | ip[0] | HALF_UP);
    return RND_W'(ip) + RND_W'(up);
  endfunction

  state_t                  state_q, state_d;
  logic [FW-1:0]           factor_q, factor_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]   src_q, src_d;
  logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic [ADDR_WIDTH:0]     map_count_q, map_count_d;
  logic                    done_q, done_d;
  logic [RND_W-1:0]        rnd;

  // Next-state logic: start acceptance, handshake advance and termination.
  always_comb begin
    state_d     = state_q;
    factor_d    = factor_q;
    acc_d       = acc_q;
    src_d       = src_q;
    dst_d       = dst_q;
    count_d     = count_q;
    map_count_d = map_count_q;
    done_d      = 1'b0;
    // acc_q already holds (src+1) * factor, so this is the next bin's dst.
    rnd         = round_acc(acc_q);
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          factor_d = shift_factor;
          acc_d    = ACC_W'(shift_factor);
          src_d    = '0;
          dst_d    = '0;
          count_d  = '0;
        end
      end
      RUN: begin
        if (map_ready) begin
          count_d = count_q + 1'b1;
          // The compare uses the full rounded width; dst is monotonic, so
          // the first out-of-range bin ends the frame.
          if (src_q == LAST_SRC || rnd >= N_BINS_R) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            map_count_d = count_q + 1'b1;
          end else begin
            src_d = src_q + 1'b1;
            dst_d = rnd[ADDR_WIDTH-1:0];
            acc_d = acc_q + ACC_W'(factor_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      count_q     <= '0;
      map_count_q <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      count_q     <= count_d;
      map_count_q <= map_count_d;
    end
  end

  // Datapath registers. These are always rewritten on start, so they need no reset.
  always_ff @(posedge clk) begin
    factor_q <= factor_d;
    acc_q    <= acc_d;
  end

  assign busy      = (state_q == RUN);
  assign map_valid = (state_q == RUN);
  assign done      = done_q;
  assign src_addr  = src_q;
  assign dst_addr  = dst_q;
  assign map_count = map_count_q;

endmodule

// File: tb/tb_bin_shift_scheduler.sv
// Directed bench for bin_shift_scheduler with N_BINS=8. Expected destinations
// are hand-computed round-to-nearest values of k * factor.
module tb_bin_shift_scheduler;

  localparam int INT_WIDTH  = 11;
  localparam int FRAC_WIDTH = 21;
  localparam int N_BINS     = 8;
  localparam int ADDR_WIDTH = 3;

  localparam logic [31:0] F_0    = 32'h0000_0000;
  localparam logic [31:0] F_1_0  = 32'h0020_0000;
  localparam logic [31:0] F_1_5  = 32'h0030_0000;
  localparam logic [31:0] F_0_75 = 32'h0018_0000;

  logic                            clk = 1'b0;
  logic                            reset;
  logic                            start;
  logic [INT_WIDTH+FRAC_WIDTH-1:0] shift_factor;
  logic                            busy;
  logic                            done;
  logic                            map_valid;
  logic                            map_ready;
  logic [ADDR_WIDTH-1:0]           src_addr;
  logic [ADDR_WIDTH-1:0]           dst_addr;
  logic [ADDR_WIDTH:0]             map_count;

  int checks = 0;
  int errors = 0;

  bin_shift_scheduler #(
    .INT_WIDTH (INT_WIDTH),
    .FRAC_WIDTH(FRAC_WIDTH),
    .N_BINS    (N_BINS),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .shift_factor(shift_factor),
    .busy        (busy),
    .done        (done),
    .map_valid   (map_valid),
    .map_ready   (map_ready),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .map_count   (map_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_pair(input int k, input int d);
    check($sformatf("valid k%0d", k), 32'(map_valid), 32'd1);
    check($sformatf("busy k%0d", k), 32'(busy), 32'd1);
    check($sformatf("done low k%0d", k), 32'(done), 32'd0);
    check($sformatf("src k%0d", k), 32'(src_addr), 32'(k));
    check($sformatf("dst k%0d", k), 32'(dst_addr), 32'(d));
  endtask

  // Accept the frame at the next rising edge; returns at the first pair.
  task automatic start_frame(input logic [31:0] f);
    @(negedge clk);
    shift_factor = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks n pairs, optionally stalling on one pair or pulsing start mid-frame.
  task automatic run_seq(input int n, input int d[8], input int stall_at, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      check_pair(i, d[i]);
      if (i == stall_at) begin
        map_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_pair(i, d[i]);
        end
        map_ready = 1'b1;
      end
      if (i == pulse_at) begin
        start = 1'b1;
        shift_factor = F_1_0;
      end
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic finish_frame(input int cnt);
    check("done pulse", 32'(done), 32'd1);
    check("busy end", 32'(busy), 32'd0);
    check("valid end", 32'(map_valid), 32'd0);
    check("map_count", 32'(map_count), 32'(cnt));
    @(negedge clk);
    check("done one cycle", 32'(done), 32'd0);
    check("map_count held", 32'(map_count), 32'(cnt));
  endtask

  initial begin
    int d[8];
    reset = 1'b1;
    start = 1'b0;
    map_ready = 1'b1;
    shift_factor = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst valid", 32'(map_valid), 32'd0);
    check("rst src", 32'(src_addr), 32'd0);
    check("rst dst", 32'(dst_addr), 32'd0);
    check("rst count", 32'(map_count), 32'd0);

    // Factor 1.0: identity map, all 8 bins.
    d = '{0, 1, 2, 3, 4, 5, 6, 7};
    start_frame(F_1_0);
    run_seq(8, d, -1, -1);
    finish_frame(8);

    // Factor 1.5: bin 5 rounds to 8 and ends the frame after 5 pairs.
`ifdef BIN_SHIFT_ROUND_EVEN_EN
    d = '{0, 2, 3, 4, 6, 0, 0, 0};
`else
    d = '{0, 2, 3, 5, 6, 0, 0, 0};
`endif
    start_frame(F_1_5);
    run_seq(5, d, -1, -1);
    finish_frame(5);

    // Factor 0.75 with a 3-cycle stall on pair 2.
`ifdef BIN_SHIFT_ROUND_EVEN_EN
    d = '{0, 1, 2, 2, 3, 4, 4, 5};
`else
    d = '{0, 1, 2, 2, 3, 4, 5, 5};
`endif
    start_frame(F_0_75);
    run_seq(8, d, 2, -1);
    finish_frame(8);

    // Factor 0, with start (and a new factor) pulsed mid-frame.
    d = '{0, 0, 0, 0, 0, 0, 0, 0};
    start_frame(F_0);
    run_seq(8, d, -1, 3);
    finish_frame(8);

    // Reset while pair 3 is being presented.
    d = '{0, 1, 2, 3, 4, 5, 6, 7};
    start_frame(F_1_0);
    run_seq(3, d, -1, -1);
    check_pair(3, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort valid", 32'(map_valid), 32'd0);
    check("abort done", 32'(done), 32'd0);
    @(negedge clk);
    check("abort no done", 32'(done), 32'd0);
    start_frame(F_1_0);
    run_seq(8, d, -1, -1);
    finish_frame(8);

    // Start held high through the done cycle starts a second frame at once.
    start_frame(F_1_0);
    run_seq(7, d, -1, -1);
    check_pair(7, 7);
    start = 1'b1;
    shift_factor = F_1_5;
    @(negedge clk);
    check("b2b done", 32'(done), 32'd1);
    check("b2b count", 32'(map_count), 32'd8);
    @(negedge clk);
    start = 1'b0;
    check("b2b done clr", 32'(done), 32'd0);
`ifdef BIN_SHIFT_ROUND_EVEN_EN
    d = '{0, 2, 3, 4, 6, 0, 0, 0};
`else
    d = '{0, 2, 3, 5, 6, 0, 0, 0};
`endif
    run_seq(5, d, -1, -1);
    finish_frame(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
